// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard unit:
//               FSM state encoding, E-stage operand forward-select codes and
//               a helper that sizes the multi-cycle stall counter.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hzState_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Width able to hold 0..stallCycles, never narrower than one bit.
  function automatic int cntWidth(input int stallCycles);
    return (stallCycles < 1) ? 1 : $clog2(stallCycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ============================================================================
// Module      : fwd_select
// Description : Forwarding comparator for one E-stage source operand.
//               MEM-stage result wins over WB; x0 is never forwarded.
// Ports       : Rs         - E-stage source register
//               RdM, RdW   - MEM / WB destination registers
//               RegWriteM  - MEM instruction writes the register file
//               RegWriteW  - WB instruction writes the register file
//               Fwd        - operand mux select (FWD_RF / FWD_WB / FWD_MEM)
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] Rs,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  output logic [1:0]        Fwd
);

  logic w_rsNonZero;

  assign w_rsNonZero = (Rs != '0);

  always_comb begin
    Fwd = FWD_RF;
    if (RegWriteM && (Rs == RdM) && w_rsNonZero) begin
      Fwd = FWD_MEM;
    end else if (RegWriteW && (Rs == RdW) && w_rsNonZero) begin
      Fwd = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit_mc
// Description : Hazard unit for the 5-stage RV32I core. Provides E-stage
//               operand forwarding, load-use stall, branch flush and an
//               execute-stage stall for multi-cycle (MUL/DIV) operations.
//               Optional feature macro: HAZARD_PERF_EN enables saturating
//               performance counters; otherwise the counter outputs are 0.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               Rs1D, Rs2D, Rs1UsedD, Rs2UsedD - decode-stage operands
//               Rs1E, Rs2E, RdE            - execute-stage registers
//               RdM, RdW                   - MEM / WB destinations
//               RegWriteE/M/W              - stage writes register file
//               ResultSrcE0                - E instruction is a load
//               PCSrcE                     - taken branch/jump in E
//               MdStartE                   - E instruction is multi-cycle
//               ForwardAE, ForwardBE       - E operand mux selects
//               StallF/D/E, FlushD/E/M     - pipeline register controls
//               LuStallCnt, MdStallCnt, FlushCnt - performance counters
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int MD_STALL = 4,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic              Rs1UsedD,
  input  logic              Rs2UsedD,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE0,
  input  logic              PCSrcE,
  input  logic              MdStartE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [PERF_W-1:0] LuStallCnt,
  output logic [PERF_W-1:0] MdStallCnt,
  output logic [PERF_W-1:0] FlushCnt
);

  localparam int               CNT_W     = cntWidth(MD_STALL);
  localparam bit               c_MD_EN   = (MD_STALL > 0);
  // The entry cycle is itself a stall cycle, so the counter is loaded with
  // one less than the total stall length.
  localparam logic [CNT_W-1:0] c_MD_LOAD = c_MD_EN ? CNT_W'(MD_STALL - 1) : '0;

  hzState_t         r_state;
  hzState_t         w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_lwHit;

  // ---------------------------------------------------------------- forwarding
  fwd_select #(.REG_AW(REG_AW)) u_fwdA (
    .Rs        (Rs1E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Fwd       (ForwardAE)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwdB (
    .Rs        (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .Fwd       (ForwardBE)
  );

  // ------------------------------------------------------------------ load-use
  // Only operands the decode instruction really reads can create a hazard,
  // and a load into x0 produces nothing to wait for.
  assign w_lwHit = ResultSrcE0 & RegWriteE & (RdE != '0) &
                   ((Rs1UsedD & (Rs1D == RdE)) | (Rs2UsedD & (Rs2D == RdE)));

  // ----------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushM      = 1'b0;
    case (r_state)
      RUN: begin
        if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (MdStartE && c_MD_EN) begin
          StallF      = 1'b1;
          StallD      = 1'b1;
          StallE      = 1'b1;
          FlushM      = 1'b1;
          w_stateNext = MD_WAIT;
          w_cntNext   = c_MD_LOAD;
        end else if (w_lwHit) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      MD_WAIT: begin
        // E holds the multi-cycle op, so branch and load-use cannot arise.
        if (r_cnt != '0) begin
          StallF    = 1'b1;
          StallD    = 1'b1;
          StallE    = 1'b1;
          FlushM    = 1'b1;
          w_cntNext = r_cnt - CNT_W'(1);
        end else begin
          w_stateNext = RUN;
        end
      end
      default: begin
        w_stateNext = RUN;
        w_cntNext   = '0;
      end
    endcase
  end

  // ------------------------------------------------------ performance counters
`ifdef HAZARD_PERF_EN
  logic              w_luStall;
  logic              w_brFlush;
  logic [PERF_W-1:0] r_luCnt;
  logic [PERF_W-1:0] r_mdCnt;
  logic [PERF_W-1:0] r_flCnt;

  // Load-use stall counts only when it is the winning RUN action.
  assign w_luStall = (r_state == RUN) & ~PCSrcE & ~(MdStartE & c_MD_EN) & w_lwHit;
  assign w_brFlush = (r_state == RUN) & PCSrcE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_luCnt <= '0;
      r_mdCnt <= '0;
      r_flCnt <= '0;
    end else begin
      if (w_luStall && (r_luCnt != '1)) r_luCnt <= r_luCnt + PERF_W'(1);
      if (StallE    && (r_mdCnt != '1)) r_mdCnt <= r_mdCnt + PERF_W'(1);
      if (w_brFlush && (r_flCnt != '1)) r_flCnt <= r_flCnt + PERF_W'(1);
    end
  end

  assign LuStallCnt = r_luCnt;
  assign MdStallCnt = r_mdCnt;
  assign FlushCnt   = r_flCnt;
`else
  assign LuStallCnt = '0;
  assign MdStallCnt = '0;
  assign FlushCnt   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit_mc
// Description : Scoreboard bench for hazard_unit_mc. Two instances share the
//               stimulus: MD_STALL = 4 / PERF_W = 32 and MD_STALL = 0 /
//               PERF_W = 2. A reference model predicts every cycle's outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit_mc;

  localparam int AW = 5;

  typedef struct {
    logic          rstN;
    logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic          rs1Used, rs2Used, regWE, regWM, regWW, resSrc, pcSrc, mdStart;
  } stim_t;

  typedef struct {
    logic [1:0]  fA, fB;
    logic [5:0]  ctl [2];
    longint      lu  [2];
    longint      md  [2];
    longint      fl  [2];
  } exp_t;

  // {StallF, StallD, StallE, FlushD, FlushE, FlushM}
  localparam logic [5:0] CTL_MD = 6'b111001;
  localparam logic [5:0] CTL_LU = 6'b110010;
  localparam logic [5:0] CTL_BR = 6'b000110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          Rs1UsedD, Rs2UsedD, RegWriteE, RegWriteM, RegWriteW;
  logic          ResultSrcE0, PCSrcE, MdStartE;

  logic [1:0]  fA0, fB0, fA1, fB1;
  logic        sF0, sD0, sE0, fD0, fE0, fM0;
  logic        sF1, sD1, sE1, fD1, fE1, fM1;
  logic [31:0] lu0, md0, fl0;
  logic [1:0]  lu1, md1, fl1;

  hazard_unit_mc #(.REG_AW(AW), .MD_STALL(4), .PERF_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1UsedD(Rs1UsedD),
    .Rs2UsedD(Rs2UsedD), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
    .ForwardAE(fA0), .ForwardBE(fB0), .StallF(sF0), .StallD(sD0), .StallE(sE0),
    .FlushD(fD0), .FlushE(fE0), .FlushM(fM0),
    .LuStallCnt(lu0), .MdStallCnt(md0), .FlushCnt(fl0)
  );

  hazard_unit_mc #(.REG_AW(AW), .MD_STALL(0), .PERF_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1UsedD(Rs1UsedD),
    .Rs2UsedD(Rs2UsedD), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
    .ForwardAE(fA1), .ForwardBE(fB1), .StallF(sF1), .StallD(sD1), .StallE(sE1),
    .FlushD(fD1), .FlushE(fE1), .FlushM(fM1),
    .LuStallCnt(lu1), .MdStallCnt(md1), .FlushCnt(fl1)
  );

  // ------------------------------------------------------------- reference model
  int     mdsCfg  [2] = '{4, 0};
  longint perfMax [2] = '{64'd4294967295, 64'd3};
`ifdef HAZARD_PERF_EN
  bit     perfOn = 1'b1;
`else
  bit     perfOn = 1'b0;
`endif
  bit     busy  [2];
  int     left  [2];
  longint cLu [2], cMd [2], cFl [2];

  exp_t   q [$];
  int     nVec = 0;
  int     nMis = 0;

  function automatic logic [1:0] fwdRef(input logic [AW-1:0] rs, rdm, rdw,
                                        input logic wm, ww);
    if (rs == 0)              return 2'b00;
    if (wm && rs == rdm)      return 2'b10;
    if (ww && rs == rdw)      return 2'b01;
    return 2'b00;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   lw, luDone, brDone;
    @(posedge clk);
    #1;
    rst_n = s.rstN; Rs1D = s.rs1D; Rs2D = s.rs2D; Rs1E = s.rs1E; Rs2E = s.rs2E;
    RdE = s.rdE; RdM = s.rdM; RdW = s.rdW; Rs1UsedD = s.rs1Used; Rs2UsedD = s.rs2Used;
    RegWriteE = s.regWE; RegWriteM = s.regWM; RegWriteW = s.regWW;
    ResultSrcE0 = s.resSrc; PCSrcE = s.pcSrc; MdStartE = s.mdStart;

    e.fA = fwdRef(s.rs1E, s.rdM, s.rdW, s.regWM, s.regWW);
    e.fB = fwdRef(s.rs2E, s.rdM, s.rdW, s.regWM, s.regWW);
    lw = s.resSrc && s.regWE && (s.rdE != 0) &&
         ((s.rs1Used && s.rs1D == s.rdE) || (s.rs2Used && s.rs2D == s.rdE));

    for (int k = 0; k < 2; k++) begin
      if (!s.rstN) begin
        busy[k] = 1'b0; left[k] = 0; cLu[k] = 0; cMd[k] = 0; cFl[k] = 0;
      end
      e.ctl[k] = 6'b0;
      luDone = 1'b0;
      brDone = 1'b0;
      if (busy[k]) begin
        if (left[k] > 0) begin
          e.ctl[k] = CTL_MD;
          left[k]--;
        end else begin
          busy[k] = 1'b0;
        end
      end else if (s.pcSrc) begin
        e.ctl[k] = CTL_BR;
        brDone   = 1'b1;
      end else if (s.mdStart && mdsCfg[k] > 0) begin
        e.ctl[k] = CTL_MD;
        busy[k]  = 1'b1;
        left[k]  = mdsCfg[k] - 1;
      end else if (lw) begin
        e.ctl[k] = CTL_LU;
        luDone   = 1'b1;
      end
      e.lu[k] = perfOn ? cLu[k] : 0;
      e.md[k] = perfOn ? cMd[k] : 0;
      e.fl[k] = perfOn ? cFl[k] : 0;
      if (s.rstN) begin
        if (luDone && cLu[k] < perfMax[k])        cLu[k]++;
        if (e.ctl[k][3] && cMd[k] < perfMax[k])   cMd[k]++;
        if (brDone && cFl[k] < perfMax[k])        cFl[k]++;
      end else begin
        busy[k] = 1'b0; left[k] = 0;
      end
    end
    q.push_back(e);
  endtask

  // ------------------------------------------------------------------- monitor
  task automatic chk(input string nm, input longint act, input longint exp);
    if (act != exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        nVec++;
        chk("ForwardAE", longint'(fA0), longint'(e.fA));
        chk("ForwardBE", longint'(fB0), longint'(e.fB));
        chk("ForwardAE_md0", longint'(fA1), longint'(e.fA));
        chk("ForwardBE_md0", longint'(fB1), longint'(e.fB));
        chk("ctl", longint'({sF0, sD0, sE0, fD0, fE0, fM0}), longint'(e.ctl[0]));
        chk("ctl_md0", longint'({sF1, sD1, sE1, fD1, fE1, fM1}), longint'(e.ctl[1]));
        chk("LuStallCnt", longint'(lu0), e.lu[0]);
        chk("MdStallCnt", longint'(md0), e.md[0]);
        chk("FlushCnt", longint'(fl0), e.fl[0]);
        chk("LuStallCnt_w2", longint'(lu1), e.lu[1]);
        chk("MdStallCnt_w2", longint'(md1), e.md[1]);
        chk("FlushCnt_w2", longint'(fl1), e.fl[1]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------ stimulus
  function automatic stim_t idle();
    stim_t s;
    s.rstN = 1'b1;
    s.rs1D = '0; s.rs2D = '0; s.rs1E = '0; s.rs2E = '0;
    s.rdE = '0; s.rdM = '0; s.rdW = '0;
    s.rs1Used = 1'b0; s.rs2Used = 1'b0; s.regWE = 1'b0; s.regWM = 1'b0;
    s.regWW = 1'b0; s.resSrc = 1'b0; s.pcSrc = 1'b0; s.mdStart = 1'b0;
    return s;
  endfunction

  function automatic stim_t loadUse(input logic [AW-1:0] rd, input logic used);
    stim_t s = idle();
    s.rdE = rd; s.resSrc = 1'b1; s.regWE = 1'b1; s.rs2D = 5'd7; s.rs2Used = used;
    return s;
  endfunction

  initial begin
    stim_t s;
    rst_n = 1'b0;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {Rs1UsedD, Rs2UsedD, RegWriteE, RegWriteM, RegWriteW} = '0;
    {ResultSrcE0, PCSrcE, MdStartE} = '0;

    // reset state
    s = idle(); s.rstN = 1'b0;
    apply(s); apply(s);
    apply(idle());

    // forwarding priority
    s = idle(); s.rs1E = 5; s.rdM = 5; s.regWM = 1; s.rdW = 5; s.regWW = 1; s.rs2E = 5;
    apply(s);
    s.regWM = 0; apply(s);
    s.rs1E = 0;  apply(s);

    // load-use: hit, operand unused, rd = x0
    apply(loadUse(5'd7, 1'b1)); apply(idle());
    apply(loadUse(5'd7, 1'b0)); apply(idle());
    apply(loadUse(5'd0, 1'b1)); apply(idle());
    apply(loadUse(5'd7, 1'b1)); apply(loadUse(5'd7, 1'b1)); apply(idle());

    // branch over load-use
    s = loadUse(5'd7, 1'b1); s.pcSrc = 1'b1; apply(s); apply(idle());

    // multi-cycle op held in E, with branch/load-use noise during the hold
    for (int i = 0; i < 5; i++) begin
      s = (i == 2) ? loadUse(5'd7, 1'b1) : idle();
      if (i == 3) s.pcSrc = 1'b1;
      s.mdStart = 1'b1;
      apply(s);
    end
    apply(idle());

    // reset on the 2nd MD_WAIT cycle, then a fresh op
    s = idle(); s.mdStart = 1'b1;
    apply(s); apply(s);
    s = idle(); s.rstN = 1'b0; apply(s);
    apply(idle());
    s = idle(); s.mdStart = 1'b1;
    for (int i = 0; i < 5; i++) apply(s);
    apply(idle());

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      s = idle();
      s.rstN    = ($urandom_range(0, 99) != 0);
      s.rs1D    = AW'($urandom_range(0, 3)); s.rs2D = AW'($urandom_range(0, 3));
      s.rs1E    = AW'($urandom_range(0, 3)); s.rs2E = AW'($urandom_range(0, 3));
      s.rdE     = AW'($urandom_range(0, 3)); s.rdM  = AW'($urandom_range(0, 3));
      s.rdW     = AW'($urandom_range(0, 3));
      s.rs1Used = 1'($urandom); s.rs2Used = 1'($urandom);
      s.regWE   = 1'($urandom); s.regWM   = 1'($urandom); s.regWW = 1'($urandom);
      s.resSrc  = 1'($urandom);
      s.pcSrc   = ($urandom_range(0, 7) == 0);
      s.mdStart = ($urandom_range(0, 7) == 0);
      apply(s);
    end

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      nMis++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
`default_nettype wire
